// File: rtl/ftoi_pipe.sv
// ============================================================================
// Module      : ftoi_pipe
// Description : Two-stage IEEE-754 single-precision to int32 converter,
//               rounding to nearest with ties away from zero and saturating.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ftoi_pipe (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] x,
  input  logic        ready,
  input  logic        stall,
  output logic [31:0] y,
  output logic        valid
);

  localparam logic [31:0] C_POS_SAT = 32'h7FFF_FFFF;
  localparam logic [31:0] C_NEG_SAT = 32'h8000_0000;

  typedef enum logic [2:0] {
    CLS_ZERO   = 3'd0,
    CLS_SMALL  = 3'd1,
    CLS_HALF   = 3'd2,
    CLS_NORMAL = 3'd3,
    CLS_SAT    = 3'd4
  } cls_t;

  logic [7:0]  x_exp;
  cls_t        cls_next;

  logic        s1_valid;
  logic        s1_sign;
  logic [7:0]  s1_exp;
  logic [23:0] s1_mant;
  cls_t        s1_cls;

  logic [4:0]  shamt;
  logic [31:0] aligned;
  logic [31:0] shifted;
  logic        round_bit;
  logic [31:0] magnitude;
  logic [31:0] result;

  assign x_exp = x[30:23];

  always_comb begin
    cls_next = CLS_ZERO;
    if (x_exp == 8'd0)
      cls_next = CLS_ZERO;
    else if (x_exp < 8'd126)
      cls_next = CLS_SMALL;
    else if (x_exp == 8'd126)
      cls_next = CLS_HALF;
    else if (x_exp <= 8'd157)
      cls_next = CLS_NORMAL;
    else
      cls_next = CLS_SAT;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_exp   <= 8'd0;
      s1_mant  <= 24'd0;
      s1_cls   <= CLS_ZERO;
    end else if (!stall) begin
      s1_valid <= ready;
      s1_sign  <= x[31];
      s1_exp   <= x_exp;
      s1_mant  <= {1'b1, x[22:0]};
      s1_cls   <= cls_next;
    end
  end

  // Normal class has 127..157 exponent, so shamt is always 1..31 when used.
  always_comb begin
    shamt     = 5'(8'd158 - s1_exp);
    aligned   = {s1_mant, 8'd0};
    shifted   = aligned >> shamt;
    round_bit = |(aligned & (32'd1 << (shamt - 5'd1)));
    magnitude = 32'd0;
    case (s1_cls)
      CLS_HALF:   magnitude = 32'd1;
      CLS_NORMAL: magnitude = shifted + {31'd0, round_bit};
      default:    magnitude = 32'd0;
    endcase
    if (s1_cls == CLS_SAT)
      result = s1_sign ? C_NEG_SAT : C_POS_SAT;
    else
      result = s1_sign ? (~magnitude + 32'd1) : magnitude;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid <= 1'b0;
      y     <= 32'd0;
    end else if (!stall) begin
      valid <= s1_valid;
      if (s1_valid)
        y <= result;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ftoi_pipe.sv
// ============================================================================
// Module      : tb_ftoi_pipe
// Description : Scoreboard bench for ftoi_pipe using directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ftoi_pipe;

  logic        clk    = 1'b0;
  logic        rstn   = 1'b0;
  logic [31:0] x      = 32'd0;
  logic        ready  = 1'b0;
  logic        stall  = 1'b0;
  logic [31:0] y;
  logic        valid;
  logic [31:0] exp_in = 32'd0;

  typedef struct {
    logic [31:0] y;
    int          due;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          ucnt = 0;
  bit          edge_stalled = 1'b1;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] snap_y;
  logic        snap_v;

  ftoi_pipe dut (
    .clk   (clk),
    .rstn  (rstn),
    .x     (x),
    .ready (ready),
    .stall (stall),
    .y     (y),
    .valid (valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Sampled at the edge; inputs only move 1 time unit later.
  always @(posedge clk) begin
    edge_stalled = stall || !rstn;
    if (rstn && !stall) begin
      ucnt++;
      if (ready) sbq.push_back('{exp_in, ucnt + 1});
    end
  end

  always @(negedge clk) begin
    if (rstn && !edge_stalled) begin
      if (valid) begin
        if (sbq.size() == 0) begin
          check("unexpected_valid", 32'd1, 32'd0);
        end else begin
          mon_e = sbq.pop_front();
          check("y", y, mon_e.y);
          check("latency", 32'(ucnt), 32'(mon_e.due));
        end
      end else if (sbq.size() > 0 && sbq[0].due <= ucnt) begin
        mon_e = sbq.pop_front();
        check("missing_valid", 32'd0, 32'd1);
      end
    end
  end

  task automatic issue(input logic [31:0] v, input logic [31:0] e);
    x = v; exp_in = e; ready = 1'b1; stall = 1'b0;
    @(posedge clk); #1;
    ready = 1'b0;
  endtask

  task automatic idle(input int n);
    ready = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #1;
    check("reset_y", y, 32'd0);
    check("reset_valid", {31'd0, valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // Back-to-back mixed signs, zero and half classes
    issue(32'h3FC0_0000, 32'h0000_0002);
    issue(32'hC020_0000, 32'hFFFF_FFFD);
    issue(32'h3EFF_FFFF, 32'h0000_0000);
    issue(32'hBF00_0000, 32'hFFFF_FFFF);
    idle(3);

    // Saturation, NaN/inf and exact boundaries
    issue(32'h4F00_0000, 32'h7FFF_FFFF);
    issue(32'hCF00_0000, 32'h8000_0000);
    issue(32'h7FC0_0000, 32'h7FFF_FFFF);
    issue(32'hFF80_0000, 32'h8000_0000);
    issue(32'h4EFF_FFFF, 32'h7FFF_FF80);
    issue(32'h3F00_0000, 32'h0000_0001);
    issue(32'h8000_0000, 32'h0000_0000);
    idle(3);

    // Stall: 3.0 accepted, three frozen edges, then one more unstalled edge
    issue(32'h4000_0000, 32'h0000_0002);
    issue(32'h4040_0000, 32'h0000_0003);
    snap_y = y; snap_v = valid;
    x = 32'hDEAD_BEEF; exp_in = 32'hDEAD_BEEF; ready = 1'b1; stall = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("stall_y", y, snap_y);
      check("stall_valid", {31'd0, valid}, {31'd0, snap_v});
    end
    stall = 1'b0; ready = 1'b0;
    idle(3);

    // Request, bubble, request
    issue(32'h4120_0000, 32'h0000_000A);
    idle(1);
    issue(32'hC120_0000, 32'hFFFF_FFF6);
    idle(3);

    // Asynchronous reset with two requests in flight
    issue(32'h4120_0000, 32'h0000_000A);
    issue(32'h4040_0000, 32'h0000_0003);
    rstn = 1'b0;
    #1;
    check("async_reset_y", y, 32'd0);
    check("async_reset_valid", {31'd0, valid}, 32'd0);
    sbq.delete();
    x = 32'h4120_0000; ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1; ready = 1'b0;
    idle(5);

    // First edge after reset release accepts normally
    issue(32'hC040_0000, 32'hFFFF_FFFD);
    idle(3);

    check("queue_drained", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
